// File: rtl/glitch_pkg.sv
// rtl/glitch_pkg.sv - shared state encoding and default field widths for the glitch sequencer
// Widths are shared with uart_handler so config fields line up end to end.
package glitch_pkg;

  localparam int DELAY_W   = 16;
  localparam int WIDTH_W   = 8;
  localparam int COUNT_W   = 8;
  localparam int SPACING_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    DELAY,
    PULSE,
    GAP,
    DONE
  } seq_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/trigger_edge_detect.sv
// rtl/trigger_edge_detect.sv - rising-edge detector for the target trigger
// TRIGGER_SYNC_EN adds a 2-flop synchronizer ahead of the edge register for asynchronous triggers.
module trigger_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  output logic trig_edge
);

  logic trig_s;
  logic trig_q;

`ifdef TRIGGER_SYNC_EN
  logic trig_meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_meta <= 1'b0;
      trig_s    <= 1'b0;
    end else begin
      trig_meta <= trigger;
      trig_s    <= trig_meta;
    end
  end
`else
  assign trig_s = trigger;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) trig_q <= 1'b0;
    else     trig_q <= trig_s;
  end

  assign trig_edge = trig_s & ~trig_q;

endmodule

// File: rtl/glitch_pulse_sequencer.sv
// rtl/glitch_pulse_sequencer.sv - arm / trigger / delay / N-pulse glitch sequencer
// Trigger synchronization is selected with TRIGGER_SYNC_EN (see trigger_edge_detect).
module glitch_pulse_sequencer #(
  parameter int DELAY_W   = glitch_pkg::DELAY_W,
  parameter int WIDTH_W   = glitch_pkg::WIDTH_W,
  parameter int COUNT_W   = glitch_pkg::COUNT_W,
  parameter int SPACING_W = glitch_pkg::SPACING_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm_i,
  input  logic                 abort_i,
  input  logic                 trigger_i,
  input  logic [DELAY_W-1:0]   delay_i,
  input  logic [WIDTH_W-1:0]   width_i,
  input  logic [COUNT_W-1:0]   num_pulses_i,
  input  logic [SPACING_W-1:0] spacing_i,
  output logic                 pulse_o,
  output logic                 busy_o,
  output logic                 armed_o,
  output logic                 done_o
);
  import glitch_pkg::*;

  // One phase counter serves delay, high and low phases, so it spans the widest field.
  localparam int PHASE_W = max_int(max_int(DELAY_W, SPACING_W), WIDTH_W);

  seq_state_t state, next_state;

  logic [DELAY_W-1:0]   delay_q;
  logic [WIDTH_W-1:0]   width_q;
  logic [COUNT_W-1:0]   num_q;
  logic [SPACING_W-1:0] spacing_q;

  logic [PHASE_W-1:0] phase_cnt;
  logic [PHASE_W-1:0] phase_val;
  logic [PHASE_W-1:0] width_m1;
  logic [PHASE_W-1:0] spacing_m1;
  logic [COUNT_W-1:0] pulse_cnt;
  logic               phase_load;
  logic               pulse_dec;
  logic               trig_edge;
  logic               arm_accept;

  trigger_edge_detect u_trigger_edge_detect (
    .clk       (clk),
    .rst       (rst),
    .trigger   (trigger_i),
    .trig_edge (trig_edge)
  );

  assign width_m1   = (width_q == '0)   ? '0 : PHASE_W'(width_q) - PHASE_W'(1);
  assign spacing_m1 = (spacing_q == '0) ? '0 : PHASE_W'(spacing_q) - PHASE_W'(1);
  assign arm_accept = (state == IDLE) && arm_i && !abort_i;

  always_comb begin
    next_state = state;
    phase_load = 1'b0;
    phase_val  = '0;
    pulse_dec  = 1'b0;
    case (state)
      IDLE: if (arm_accept) next_state = ARMED;
      ARMED: begin
        if (trig_edge) begin
          if (delay_q != '0) begin
            next_state = DELAY;
            phase_load = 1'b1;
            phase_val  = PHASE_W'(delay_q) - PHASE_W'(1);
          end else if (num_q == '0) begin
            next_state = DONE;
          end else begin
            next_state = PULSE;
            phase_load = 1'b1;
            phase_val  = width_m1;
          end
        end
      end
      DELAY: begin
        if (phase_cnt == '0) begin
          if (num_q == '0) begin
            next_state = DONE;
          end else begin
            next_state = PULSE;
            phase_load = 1'b1;
            phase_val  = width_m1;
          end
        end
      end
      PULSE: begin
        if (phase_cnt == '0) begin
          pulse_dec = 1'b1;
          if (pulse_cnt > COUNT_W'(1)) begin
            next_state = GAP;
            phase_load = 1'b1;
            phase_val  = spacing_m1;
          end else begin
            next_state = DONE;
          end
        end
      end
      GAP: begin
        if (phase_cnt == '0) begin
          next_state = PULSE;
          phase_load = 1'b1;
          phase_val  = width_m1;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (abort_i) begin
      next_state = IDLE;
      phase_load = 1'b0;
      pulse_dec  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      delay_q   <= '0;
      width_q   <= '0;
      num_q     <= '0;
      spacing_q <= '0;
    end else if (arm_accept) begin
      delay_q   <= delay_i;
      width_q   <= width_i;
      num_q     <= num_pulses_i;
      spacing_q <= spacing_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_cnt <= '0;
      pulse_cnt <= '0;
    end else begin
      if (arm_accept)     pulse_cnt <= num_pulses_i;
      else if (pulse_dec) pulse_cnt <= pulse_cnt - COUNT_W'(1);
      if (phase_load)            phase_cnt <= phase_val;
      else if (phase_cnt != '0)  phase_cnt <= phase_cnt - PHASE_W'(1);
    end
  end

  // Outputs trail the state by one edge; abort clears them on the same edge it is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_o <= 1'b0;
      busy_o  <= 1'b0;
      armed_o <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      pulse_o <= (state == PULSE) && !abort_i;
      busy_o  <= (state != IDLE)  && !abort_i;
      armed_o <= (state == ARMED) && !abort_i;
      done_o  <= (state == DONE)  && !abort_i;
    end
  end

endmodule

// File: tb/tb_glitch_pulse_sequencer.sv
// tb/tb_glitch_pulse_sequencer.sv - directed self-checking bench for glitch_pulse_sequencer
// Expected timelines are shifted by the synchronizer depth when TRIGGER_SYNC_EN is defined.
module tb_glitch_pulse_sequencer;

`ifdef TRIGGER_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        arm_i;
  logic        abort_i;
  logic        trigger_i;
  logic [15:0] delay_i;
  logic [7:0]  width_i;
  logic [7:0]  num_pulses_i;
  logic [15:0] spacing_i;
  logic        pulse_o;
  logic        busy_o;
  logic        armed_o;
  logic        done_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] pv, dv, bv;
  int          first_hi;
  int          hi_len;

  glitch_pulse_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .arm_i        (arm_i),
    .abort_i      (abort_i),
    .trigger_i    (trigger_i),
    .delay_i      (delay_i),
    .width_i      (width_i),
    .num_pulses_i (num_pulses_i),
    .spacing_i    (spacing_i),
    .pulse_o      (pulse_o),
    .busy_o       (busy_o),
    .armed_o      (armed_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic arm_cfg(input logic [15:0] d, input logic [7:0] w, input logic [7:0] n,
                         input logic [15:0] s);
    delay_i = d; width_i = w; num_pulses_i = n; spacing_i = s;
    arm_i = 1'b1;
    tick;
    arm_i = 1'b0;
    delay_i = 16'hbeef; width_i = 8'h77; num_pulses_i = 8'h09; spacing_i = 16'h1234;
    tick;
  endtask

  // Bit k of pv/dv/bv holds the output sampled just after edge T+k (k=0 is the trigger edge).
  task automatic capture(input int arm_k, input int abort_k);
    pv = '0; dv = '0; bv = '0;
    trigger_i = 1'b1;
    for (int k = 0; k < 32; k++) begin
      tick;
      pv[k] = pulse_o; dv[k] = done_o; bv[k] = busy_o;
      arm_i   = (k == arm_k);
      abort_i = (k == abort_k);
    end
    arm_i = 1'b0; abort_i = 1'b0; trigger_i = 1'b0;
    tick;
  endtask

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    rst = 1'b1; arm_i = 1'b0; abort_i = 1'b0; trigger_i = 1'b0;
    delay_i = '0; width_i = '0; num_pulses_i = '0; spacing_i = '0;
    repeat (3) tick;
    check_eq("reset_outputs", {pulse_o, busy_o, armed_o, done_o}, 4'b0000);
    rst = 1'b0;
    tick;
    check_eq("post_reset_idle", {pulse_o, busy_o, armed_o, done_o}, 4'b0000);

    arm_cfg(16'd10, 8'd3, 8'd2, 16'd5);
    check_eq("armed_flags", {armed_o, busy_o}, 2'b11);
    capture(-1, -1);
    check_eq("t1_pulse", pv, 32'h0038_3800 << S);
    check_eq("t1_done", dv, 32'h0040_0000 << S);
    check_eq("t1_busy", bv, (32'h1 << (23 + S)) - 32'h1);

    arm_cfg(16'd0, 8'd0, 8'd1, 16'd7);
    capture(-1, -1);
    check_eq("t2_pulse", pv, 32'h2 << S);
    check_eq("t2_done", dv, 32'h4 << S);

    arm_cfg(16'd4, 8'd3, 8'd0, 16'd2);
    capture(-1, -1);
    check_eq("t3_pulse", pv, 32'h0);
    check_eq("t3_done", dv, 32'h20 << S);
    check_eq("t3_busy", bv, (32'h1 << (6 + S)) - 32'h1);

    trigger_i = 1'b1;
    repeat (3) tick;
    arm_cfg(16'd6, 8'd2, 8'd1, 16'd1);
    repeat (4) tick;
    check_eq("held_trigger_no_start", {armed_o, pulse_o, busy_o}, 3'b101);
    trigger_i = 1'b0;
    repeat (3) tick;
    delay_i = 16'd0; width_i = 8'd5; num_pulses_i = 8'd3; spacing_i = 16'd1;
    capture(2 + S, -1);
    check_eq("t4_pulse_cfg_kept", pv, 32'h180 << S);
    check_eq("t4_done", dv, 32'h200 << S);

    arm_cfg(16'd2, 8'd4, 8'd2, 16'd3);
    capture(-1, 4 + S);
    check_eq("t5_abort_pulse", pv, 32'h18 << S);
    check_eq("t5_abort_no_done", dv, 32'h0);
    check_eq("t5_abort_busy", bv, (32'h1 << (5 + S)) - 32'h1);
    trigger_i = 1'b1;
    repeat (6) tick;
    check_eq("t5_idle_after_abort", {pulse_o, busy_o, armed_o, done_o}, 4'b0000);
    trigger_i = 1'b0;
    tick;

    delay_i = 16'd1; width_i = 8'd1; num_pulses_i = 8'd1; spacing_i = 16'd1;
    abort_i = 1'b1; arm_i = 1'b1;
    tick;
    abort_i = 1'b0; arm_i = 1'b0;
    tick;
    check_eq("abort_beats_arm", {armed_o, busy_o}, 2'b00);

    arm_cfg(16'd0, 8'd1, 8'd1, 16'd1);
    trigger_i = 1'b1; abort_i = 1'b1;
    tick;
    abort_i = 1'b0;
    pv = '0;
    for (int k = 0; k < 8; k++) begin
      tick;
      pv[k] = pulse_o;
    end
    trigger_i = 1'b0;
    check_eq("abort_beats_trigger_pulse", pv, 32'h0);
    check_eq("abort_beats_trigger_busy", {busy_o, armed_o}, 2'b00);
    tick;

    arm_cfg(16'd1, 8'd10, 8'd1, 16'd1);
    trigger_i = 1'b1;
    repeat (4 + S) tick;
    check_eq("rst_mid_pulse_before", pulse_o, 1'b1);
    #2 rst = 1'b1;
    #1 check_eq("rst_mid_pulse_async", {pulse_o, busy_o}, 2'b00);
    trigger_i = 1'b0;
    tick;
    rst = 1'b0;
    tick;

    arm_cfg(16'd65535, 8'd255, 8'd1, 16'd3);
    trigger_i = 1'b1;
    first_hi = -1;
    for (int k = 0; k < 70000; k++) begin
      tick;
      if (pulse_o) begin
        first_hi = k;
        break;
      end
    end
    trigger_i = 1'b0;
    check_eq("max_delay_first_pulse", first_hi, 65536 + S);
    hi_len = 0;
    for (int j = 0; j < 300; j++) begin
      if (!pulse_o) break;
      hi_len++;
      tick;
    end
    check_eq("max_width_len", hi_len, 255);
    check_eq("max_done", done_o, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
